// File: rtl/seq_signed_divider.sv
// Multicycle signed divider: non-restoring on magnitudes, one quotient bit per clock.
// Define DIV_REMAINDER_EN to add the data_remainder output.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic [WIDTH-1:0] sum
);
    assign sum = op ? a - b : a + b;
endmodule

module complement #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             ovf
);
    assign y   = ~x + 1'b1;
    assign ovf = (x == {1'b1, {(WIDTH-1){1'b0}}});
endmodule

module div_control #(
    parameter int W = 32
) (
    input  logic clock,
    input  logic reset_n,
    input  logic start,
    output logic busy,
    output logic last
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [5:0] LAST = 6'(W);

    state_t     state;
    logic [5:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            count <= '0;
        end else if (start) begin
            state <= RUN;
            count <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (count == LAST) state <= DONE;
                    else               count <= count + 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    count <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign last = (count == LAST);
endmodule

module seq_signed_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  ctrl_DIV,
    input  logic [DATA_WIDTH-1:0] data_operandA,
    input  logic [DATA_WIDTH-1:0] data_operandB,
    output logic [DATA_WIDTH-1:0] data_result,
    output logic                  data_exception,
    output logic                  data_resultRDY
`ifdef DIV_REMAINDER_EN
    ,
    output logic [DATA_WIDTH-1:0] data_remainder
`endif
);
    localparam int W = DATA_WIDTH;

    logic [W-1:0] neg_a, neg_b, neg_q, mag_a, mag_b, q_signed;
    logic [W-1:0] divisor;
    logic [W:0]   next_rem;
    logic [2*W:0] work;
    logic         sign, divzero, busy, last;
    logic         unused_ovf_a, unused_ovf_b, unused_ovf_q;

    complement #(W) u_neg_a (.x(data_operandA), .y(neg_a), .ovf(unused_ovf_a));
    complement #(W) u_neg_b (.x(data_operandB), .y(neg_b), .ovf(unused_ovf_b));
    complement #(W) u_neg_q (.x(work[W-1:0]), .y(neg_q), .ovf(unused_ovf_q));

    assign mag_a    = data_operandA[W-1] ? neg_a : data_operandA;
    assign mag_b    = data_operandB[W-1] ? neg_b : data_operandB;
    assign q_signed = sign ? neg_q : work[W-1:0];

    // Sign of the current partial remainder picks subtract (>= 0) or add.
    alu #(W+1) u_slice (
        .a   (work[2*W-1:W-1]),
        .b   ({1'b0, divisor}),
        .op  (~work[2*W]),
        .sum (next_rem)
    );

    div_control #(W) u_ctrl (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (ctrl_DIV),
        .busy    (busy),
        .last    (last)
    );

`ifdef DIV_REMAINDER_EN
    logic         a_sign, unused_ovf_r;
    logic [W-1:0] rem_fix, neg_r;

    // A negative final remainder is corrected by adding the divisor back.
    alu #(W) u_fix (
        .a   (work[2*W-1:W]),
        .b   (divisor),
        .op  (1'b0),
        .sum (rem_fix)
    );
    complement #(W) u_neg_r (
        .x   (work[2*W] ? rem_fix : work[2*W-1:W]),
        .y   (neg_r),
        .ovf (unused_ovf_r)
    );
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            work           <= '0;
            divisor        <= '0;
            sign           <= 1'b0;
            divzero        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
`ifdef DIV_REMAINDER_EN
            a_sign         <= 1'b0;
            data_remainder <= '0;
`endif
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_DIV) begin
                work    <= {{(W+1){1'b0}}, mag_a};
                divisor <= mag_b;
                sign    <= data_operandA[W-1] ^ data_operandB[W-1];
                divzero <= (data_operandB == '0);
`ifdef DIV_REMAINDER_EN
                a_sign  <= data_operandA[W-1];
`endif
            end else if (busy && !last) begin
                work <= {next_rem, work[W-2:0], ~next_rem[W]};
            end else if (busy) begin
                data_resultRDY <= 1'b1;
                data_exception <= divzero;
                data_result    <= divzero ? '0 : q_signed;
`ifdef DIV_REMAINDER_EN
                if (divzero)     data_remainder <= '0;
                else if (a_sign) data_remainder <= neg_r;
                else data_remainder <= work[2*W] ? rem_fix : work[2*W-1:W];
`endif
            end
        end
    end
endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench for seq_signed_divider: directed vectors, latency and hold checks.
`timescale 1ns/1ps
module tb_seq_signed_divider;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
`ifdef DIV_REMAINDER_EN
    logic [31:0] data_remainder;
`endif

    seq_signed_divider dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
`ifdef DIV_REMAINDER_EN
        ,
        .data_remainder (data_remainder)
`endif
    );

    typedef struct {
        logic [31:0] q;
        logic        e;
        logic [31:0] r;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest expected entry.
    always @(negedge clock) begin
        if (reset_n && data_resultRDY) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL strobe: unexpected ready at edge %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", data_result, e.q);
                chk("exception", {31'b0, data_exception}, {31'b0, e.e});
                chk("ready_edge", cyc, e.due);
`ifdef DIV_REMAINDER_EN
                chk("remainder", data_remainder, e.r);
`endif
            end
        end
    end

    task automatic wait_done();
        for (int i = 0; i < 45 && sb.size() != 0; i++) begin
            @(negedge clock);
            #1;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: ready missing, got 0 expected 1");
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic e, input logic [31:0] r);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV = 1'b1;
        sb.push_back('{q, e, r, cyc + 34});
        @(negedge clock);
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        wait_done();
    endtask

    initial begin
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("reset_result", data_result, 32'h0);
        chk("reset_exception", {31'b0, data_exception}, 32'h0);
        chk("reset_ready", {31'b0, data_resultRDY}, 32'h0);

        run_op(32'd100, 32'd7, 32'h0000000E, 1'b0, 32'd2);
        repeat (3) @(negedge clock);
        chk("hold_result", data_result, 32'h0000000E);
        run_op(-32'sd100, 32'd7, 32'hFFFFFFF2, 1'b0, 32'hFFFFFFFE);
        run_op(32'd100, -32'sd7, 32'hFFFFFFF2, 1'b0, 32'd2);
        run_op(-32'sd100, -32'sd7, 32'h0000000E, 1'b0, 32'hFFFFFFFE);
        run_op(32'd1234, 32'd0, 32'h0, 1'b1, 32'h0);
        run_op(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 32'h0);
        run_op(32'd5, 32'd9, 32'h0, 1'b0, 32'd5);
        run_op(32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 1'b0, 32'h0);

        // Abort: restart 10 edges into 100/7 with 50/5.
        @(negedge clock);
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        ctrl_DIV = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        repeat (9) @(negedge clock);
        data_operandA = 32'd50;
        data_operandB = 32'd5;
        ctrl_DIV = 1'b1;
        sb.push_back('{32'd10, 1'b0, 32'd0, cyc + 34});
        @(negedge clock);
        ctrl_DIV = 1'b0;
        wait_done();

        // Asynchronous reset 15 edges into an operation.
        @(negedge clock);
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        ctrl_DIV = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        repeat (14) @(negedge clock);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_result", data_result, 32'h0);
        chk("async_exception", {31'b0, data_exception}, 32'h0);
        chk("async_ready", {31'b0, data_resultRDY}, 32'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        chk("after_reset_result", data_result, 32'h0);

        run_op(32'd7, 32'd2, 32'd3, 1'b0, 32'd1);
        repeat (3) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
